// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-to-parallel receiver with a one-word holding
// buffer on a valid/ready output and sticky overrun / framing error flags.
//
// Output handshake: a word is offered while dout_valid=1; dout and
// dout_valid do not change until an edge that samples dout_ready=1, and
// that edge is the transfer. dout_ready while dout_valid=0 is ignored.
//
// state_dbg exposes the FSM state: 0 = HUNT (discarding), 1 = SHIFT.
module sipo_rx #(
   parameter int WIDTH     = 4,
   parameter bit SYNC_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   input  logic             si_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err,
   input  logic             clr_err,
   output logic             state_dbg
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam state_t RST_STATE = SYNC_MODE ? HUNT : SHIFT;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;

   logic [WIDTH-1:0] word;
   logic             take_bit;
   logic             realign;
   logic             complete;
   logic             frame_err_set;
   logic             overrun_set;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RST_STATE;
      else     state_q <= state_d;
   end

   // FSM next state: a framed bit leaves HUNT; SHIFT is only left by reset
   always_comb begin
      state_d = state_q;
      if (state_q == HUNT && si_valid && frame_start) state_d = SHIFT;
   end

   // FSM outputs, decoded from registers only
   always_comb begin
      busy      = (state_q == SHIFT) && (cnt_q != '0);
      state_dbg = state_q;
   end

   // Bit assembly, word completion, handshake and error flag next values
   always_comb begin
      word          = {si, sr_q[WIDTH-1:1]};
      realign       = si_valid && frame_start;
      take_bit      = si_valid && ((state_q == SHIFT) || frame_start);
      complete      = si_valid && !frame_start && (state_q == SHIFT) && (cnt_q == CNT_LAST);
      frame_err_set = realign && (state_q == SHIFT) && (cnt_q != '0);

      sr_d         = sr_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_set  = 1'b0;

      // A framed bit always restarts the count at 1; stale bits of an
      // abandoned partial word are pushed out by the next WIDTH-1 shifts.
      if (take_bit) begin
         sr_d = word;
         if (realign)       cnt_d = CNT_ONE;
         else if (complete) cnt_d = '0;
         else               cnt_d = cnt_q + 1'b1;
      end

      if (complete) begin
         if (!dout_valid_q || dout_ready) begin
            dout_d       = word;
            dout_valid_d = 1'b1;
         end else begin
            overrun_set = 1'b1;
         end
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end

      // A set in the same cycle as clr_err takes priority
      overrun_d   = (overrun_q   && !clr_err) || overrun_set;
      frame_err_d = (frame_err_q && !clr_err) || frame_err_set;
   end

   // Datapath and flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q         <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;

endmodule
